// File: rtl/div_pkg.sv
// Shared types and constants for the divider arbiter and its round-robin picker.
package div_pkg;

  localparam int DIV_W  = 19;
  localparam int DIV_QW = 8;

  localparam logic [DIV_QW-1:0] DIV_ERR_Q = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } div_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: grants the first requester at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            found
);

  logic [PW-1:0] pos;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int j = 0; j < NREQ; j++) begin
      pos = PW'((int'(ptr) + j) % NREQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider among NREQ requesters, serving them round-robin
// and returning each quotient with a one-cycle valid strobe to its owner.
module div_arbiter
  import div_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DIV_W,
  parameter int QW   = DIV_QW,
  parameter int TMO  = 63
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   dividend,
  input  logic [NREQ*W-1:0]   divisor,
  output logic [NREQ-1:0]     ack,
  output logic [QW-1:0]       q_out,
  output logic [NREQ-1:0]     q_valid,
  output logic                q_err,
  output logic                busy,
  output logic                div_sample,
  output logic [W-1:0]        div_count,
  output logic [W-1:0]        div_dsor,
  input  logic [QW-1:0]       div_Q,
  input  logic                div_done,
  output div_arb_state_t      state
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TMO + 1);

  // Handshake: req is a level; ack[i] pulses for one cycle on the edge that
  // captures requester i's operands, after which it may drop req. q_valid[i]
  // pulses once per job and qualifies q_out/q_err, which hold until the next job.

  div_arb_state_t cur_state, nxt_state;
  logic [PW-1:0]   ptr, nxt_ptr;
  logic [PW-1:0]   owner, nxt_owner;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic            done_q;
  logic [QW-1:0]   res_q, nxt_res;
  logic            res_err, nxt_res_err;

  logic [NREQ-1:0] nxt_ack, nxt_qvalid;
  logic [QW-1:0]   nxt_qout;
  logic            nxt_qerr, nxt_sample;
  logic [W-1:0]    nxt_count, nxt_dsor;

  logic [NREQ-1:0] grant;
  logic            found;
  logic [PW-1:0]   gidx;
  logic [W-1:0]    sel_a, sel_b;
  logic            done_rise;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .found (found)
  );

  always_comb begin
    gidx  = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gidx  = PW'(i);
        sel_a = dividend[i*W +: W];
        sel_b = divisor[i*W +: W];
      end
    end
  end

  // A done left high from an earlier job must not count as a fresh completion.
  assign done_rise = div_done & ~done_q;

  always_comb begin
    nxt_state   = cur_state;
    nxt_ptr     = ptr;
    nxt_owner   = owner;
    nxt_cnt     = cnt;
    nxt_res     = res_q;
    nxt_res_err = res_err;
    nxt_ack     = '0;
    nxt_qvalid  = '0;
    nxt_sample  = 1'b0;
    nxt_qout    = q_out;
    nxt_qerr    = q_err;
    nxt_count   = div_count;
    nxt_dsor    = div_dsor;

    case (cur_state)
      ST_IDLE: begin
        if (found) begin
          nxt_ack   = grant;
          nxt_count = sel_a;
          nxt_dsor  = sel_b;
          nxt_owner = gidx;
          nxt_state = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (div_dsor == '0) begin
          nxt_res     = DIV_ERR_Q;
          nxt_res_err = 1'b1;
          nxt_state   = ST_DELIVER;
        end else begin
          nxt_sample = 1'b1;
          nxt_cnt    = '0;
          nxt_state  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_rise) begin
          nxt_res     = div_Q;
          nxt_res_err = 1'b0;
          nxt_state   = ST_DELIVER;
        end else if (cnt == CW'(TMO)) begin
          nxt_res     = DIV_ERR_Q;
          nxt_res_err = 1'b1;
          nxt_state   = ST_DELIVER;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      ST_DELIVER: begin
        nxt_qvalid[owner] = 1'b1;
        nxt_qout          = res_q;
        nxt_qerr          = res_err;
        nxt_ptr           = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
        nxt_state         = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      cur_state  <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      done_q     <= 1'b0;
      res_q      <= '0;
      res_err    <= 1'b0;
      ack        <= '0;
      q_valid    <= '0;
      q_out      <= '0;
      q_err      <= 1'b0;
      busy       <= 1'b0;
      div_sample <= 1'b0;
      div_count  <= '0;
      div_dsor   <= '0;
    end else begin
      cur_state  <= nxt_state;
      ptr        <= nxt_ptr;
      owner      <= nxt_owner;
      cnt        <= nxt_cnt;
      done_q     <= div_done;
      res_q      <= nxt_res;
      res_err    <= nxt_res_err;
      ack        <= nxt_ack;
      q_valid    <= nxt_qvalid;
      q_out      <= nxt_qout;
      q_err      <= nxt_qerr;
      busy       <= (nxt_state != ST_IDLE);
      div_sample <= nxt_sample;
      div_count  <= nxt_count;
      div_dsor   <= nxt_dsor;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter with a behavioural divider stub (normal, never-done and
// stale-done modes) and a scoreboard of expected per-job results.
module tb_div_arbiter;
  import div_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = DIV_W;
  localparam int QW   = DIV_QW;
  localparam int TMO  = 63;
  localparam int EW   = 3 + 1 + QW;

  logic                clk = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   dividend, divisor;
  logic [NREQ-1:0]     ack, q_valid;
  logic [QW-1:0]       q_out;
  logic                q_err, busy, div_sample;
  logic [W-1:0]        div_count, div_dsor;
  logic [QW-1:0]       div_Q;
  logic                div_done;
  div_arb_state_t      state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  // Divider stub: 0 = normal, 1 = never done, 2 = stale done held over sample.
  int          stub_mode = 0;
  int          stub_lat  = 10;
  int          stub_cnt  = 0;
  logic        stub_run  = 1'b0;
  logic [QW-1:0] stub_q  = '0;

  always #5 clk = ~clk;

  div_arbiter #(.NREQ(NREQ), .W(W), .QW(QW), .TMO(TMO)) dut (
    .clk        (clk),
    .RST        (RST),
    .req        (req),
    .dividend   (dividend),
    .divisor    (divisor),
    .ack        (ack),
    .q_out      (q_out),
    .q_valid    (q_valid),
    .q_err      (q_err),
    .busy       (busy),
    .div_sample (div_sample),
    .div_count  (div_count),
    .div_dsor   (div_dsor),
    .div_Q      (div_Q),
    .div_done   (div_done),
    .state      (state)
  );

  function automatic logic [QW-1:0] q_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] t;
    t = (64'(a) << QW) / 64'(b);
    return t[QW-1:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!RST) begin
      div_done = 1'b0;
      div_Q    = '0;
      stub_cnt = 0;
      stub_run = 1'b0;
    end else if (div_sample) begin
      stub_q   = q_model(div_count, div_dsor);
      stub_cnt = 0;
      stub_run = 1'b1;
      if (stub_mode != 2) div_done = 1'b0;
    end else if (stub_run) begin
      stub_cnt++;
      if (stub_mode == 2 && stub_cnt == 2) div_done = 1'b0;
      if (stub_mode != 1 && stub_cnt == stub_lat) begin
        div_done = 1'b1;
        div_Q    = stub_q;
        stub_run = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (RST && q_valid != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("qv_unexpected", 32'(q_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("qv_owner", 32'(q_valid), 32'd1 << mon_e[EW-1 -: 3]);
        check_eq("q_out", 32'(q_out), 32'(mon_e[QW-1:0]));
        check_eq("q_err", 32'(q_err), 32'(mon_e[QW]));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  // lat = cycles from the cycle req is driven to the q_valid cycle
  task automatic run_job(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [QW-1:0] eq, input logic eerr, input int lat);
    int n;
    dividend[idx*W +: W] = a;
    divisor[idx*W +: W]  = b;
    req[idx]             = 1'b1;
    exp_q.push_back({3'(idx), eerr, eq});
    tick();
    check_eq("ack", 32'(ack), 32'd1 << idx);
    check_eq("busy", 32'(busy), 32'd1);
    req[idx] = 1'b0;
    tick();
    check_eq("sample", 32'(div_sample), 32'(b != '0));
    n = 2;
    while (q_valid == '0 && n < 300) begin
      tick();
      n++;
    end
    check_eq("latency", n, lat);
    check_eq("hold_count", 32'(div_count), 32'(a));
    check_eq("hold_dsor", 32'(div_dsor), 32'(b));
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [NREQ-1:0] seen;
    int n, ri, rl;

    RST      = 1'b0;
    req      = '0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_qv", 32'(q_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sample", 32'(div_sample), 32'd0);
    check_eq("rst_qout", 32'(q_out), 32'd0);
    check_eq("rst_qerr", 32'(q_err), 32'd0);
    check_eq("rst_count", 32'(div_count), 32'd0);
    check_eq("rst_dsor", 32'(div_dsor), 32'd0);
    check_eq("rst_state", 32'(state), 32'(ST_IDLE));
    RST = 1'b1;
    tick();

    stub_mode = 0; stub_lat = 10;
    run_job(0, 19'd137260, 19'd152890, 8'd229, 1'b0, 14);
    run_job(2, 19'd5000, 19'd0, 8'hFF, 1'b1, 3);

    stub_mode = 1;
    run_job(1, 19'd1000, 19'd2000, 8'hFF, 1'b1, TMO + 4);

    stub_mode = 0; stub_lat = 10;
    run_job(0, 19'd1000, 19'd3000, 8'd85, 1'b0, 14);
    check_eq("stale_pre_done", 32'(div_done), 32'd1);
    stub_mode = 2; stub_lat = 34;
    run_job(1, 19'd50000, 19'd60000, 8'd213, 1'b0, 38);

    stub_mode = 0;
    for (int k = 0; k < 4; k++) begin
      rb = 19'($urandom_range(2, 524287));
      ra = 19'($urandom_range(0, int'(rb) - 1));
      ri = $urandom_range(0, NREQ - 1);
      rl = $urandom_range(1, 12);
      stub_lat = rl;
      run_job(ri, ra, rb, q_model(ra, rb), 1'b0, rl + 4);
    end

    do_reset();
    stub_lat = 5;
    for (int i = 0; i < NREQ; i++) begin
      rb = 19'($urandom_range(2, 524287));
      ra = 19'($urandom_range(0, int'(rb) - 1));
      if (i == 1) begin
        ra = 19'd37560;
        rb = 19'd302791;
      end
      dividend[i*W +: W] = ra;
      divisor[i*W +: W]  = rb;
    end
    exp_q.push_back({3'd0, 1'b0, q_model(dividend[0 +: W], divisor[0 +: W])});
    exp_q.push_back({3'd1, 1'b0, 8'd31});
    exp_q.push_back({3'd2, 1'b0, q_model(dividend[2*W +: W], divisor[2*W +: W])});
    exp_q.push_back({3'd3, 1'b0, q_model(dividend[3*W +: W], divisor[3*W +: W])});
    exp_q.push_back({3'd0, 1'b0, q_model(dividend[0 +: W], divisor[0 +: W])});
    req = '1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (ack == '0 && n < 200) begin
        tick();
        n++;
      end
      check_eq("rr_grant", 32'(ack), 32'd1 << (k % NREQ));
      if (k == 4) req = '0;
      tick();
    end
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check_eq("rr_drain", exp_q.size(), 0);
    tick();
    tick();

    stub_lat = 20;
    dividend[3*W +: W] = 19'd1000;
    divisor[3*W +: W]  = 19'd2000;
    req[3] = 1'b1;
    tick();
    check_eq("mid_ack", 32'(ack), 32'd8);
    req[3] = 1'b0;
    repeat (4) tick();
    check_eq("mid_in_wait", 32'(state), 32'(ST_WAIT));
    RST = 1'b0;
    tick();
    RST = 1'b1;
    check_eq("mid_ack0", 32'(ack), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_sample", 32'(div_sample), 32'd0);
    check_eq("mid_qout", 32'(q_out), 32'd0);
    check_eq("mid_qerr", 32'(q_err), 32'd0);
    check_eq("mid_count", 32'(div_count), 32'd0);
    check_eq("mid_dsor", 32'(div_dsor), 32'd0);
    check_eq("mid_state", 32'(state), 32'(ST_IDLE));
    seen = '0;
    repeat (30) begin
      tick();
      seen |= q_valid;
    end
    check_eq("mid_no_qv", 32'(seen), 32'd0);
    run_job(3, 19'd1000, 19'd2000, 8'd128, 1'b0, 24);

    tick();
    check_eq("final_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
